// File: rtl/bit_walk_path.sv
// Walks a bit index s across register y, updating y by a selectable rule
// whenever the selected bit is set, then pulses done once the index would overflow.
module bit_walk_path #(
    parameter int W = 8,
    parameter int LIMIT = W - 2,
    localparam int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  x,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [SW-1:0] step,
    output logic [W-1:0]  y,
    output logic [SW-1:0] s,
    output logic          b,
    output logic [SW:0]   ones,
    output logic          busy,
    output logic          done,
    output logic          s_at_limit
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // W is a power of two, so W itself is a one followed by SW zeros.
    localparam logic [SW:0]   W_C     = {1'b1, {SW{1'b0}}};
    localparam logic [SW-1:0] LIMIT_S = LIMIT[SW-1:0];
    localparam logic [SW-1:0] STEP1   = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [SW:0]   ONE_C   = {{SW{1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [W-1:0]  y_q, y_d;
    logic [SW-1:0] s_q, s_d;
    logic [SW:0]   ones_q, ones_d;
    logic [1:0]    mode_q, mode_d;
    logic [SW-1:0] step_q, step_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [W-1:0]  s_ext;
    logic [SW:0]   sum;

    assign b          = y_q[s_q];
    assign s_at_limit = (s_q == LIMIT_S);
    assign s_ext      = {{(W-SW){1'b0}}, s_q};
    assign sum        = {1'b0, s_q} + {1'b0, step_q};

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        s_d     = s_q;
        ones_d  = ones_q;
        mode_d  = mode_q;
        step_d  = step_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    y_d     = x;
                    s_d     = '0;
                    ones_d  = '0;
                    mode_d  = mode;
                    step_d  = (step == '0) ? STEP1 : step;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (b) begin
                    unique case (mode_q)
                        2'd0:    y_d = y_q + s_ext;
                        2'd1:    y_d = y_q - s_ext;
                        2'd2:    y_d = y_q + ONE_W;
                        default: y_d = y_q;
                    endcase
                    ones_d = ones_q + ONE_C;
                end
                // The index stays on its last value when the next step would leave the word.
                if (sum < W_C) begin
                    s_d = sum[SW-1:0];
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            s_q     <= '0;
            ones_q  <= '0;
            mode_q  <= '0;
            step_q  <= STEP1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            s_q     <= s_d;
            ones_q  <= ones_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign s    = s_q;
    assign ones = ones_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
